// File: rtl/video_timing_ctrl_if.sv
// Mode-configuration bus for video_timing_ctrl.
//   master: offers a mode (cfg_valid + timing fields), sees cfg_ready / cfg_err.
//   slave : the timing controller.
// Optional feature macro: VIDEO_TIMING_SYNC_POL_EN adds cfg_hpol / cfg_vpol.
interface video_timing_ctrl_if #(
  parameter int unsigned H_WIDTH    = 12,
  parameter int unsigned V_WIDTH    = 11,
  parameter int unsigned FREQ_WIDTH = 8
);
  logic                  cfg_valid;
  logic                  cfg_ready;
  logic [FREQ_WIDTH-1:0] cfg_freq;
  logic [H_WIDTH-1:0]    cfg_h_active;
  logic [H_WIDTH-1:0]    cfg_h_front;
  logic [H_WIDTH-1:0]    cfg_h_sync;
  logic [H_WIDTH-1:0]    cfg_h_back;
  logic [V_WIDTH-1:0]    cfg_v_active;
  logic [V_WIDTH-1:0]    cfg_v_front;
  logic [V_WIDTH-1:0]    cfg_v_sync;
  logic [V_WIDTH-1:0]    cfg_v_back;
  logic                  cfg_err;
`ifdef VIDEO_TIMING_SYNC_POL_EN
  logic                  cfg_hpol;
  logic                  cfg_vpol;

  modport master (
    output cfg_valid, cfg_freq, cfg_h_active, cfg_h_front, cfg_h_sync, cfg_h_back,
    output cfg_v_active, cfg_v_front, cfg_v_sync, cfg_v_back, cfg_hpol, cfg_vpol,
    input  cfg_ready, cfg_err
  );

  modport slave (
    input  cfg_valid, cfg_freq, cfg_h_active, cfg_h_front, cfg_h_sync, cfg_h_back,
    input  cfg_v_active, cfg_v_front, cfg_v_sync, cfg_v_back, cfg_hpol, cfg_vpol,
    output cfg_ready, cfg_err
  );
`else
  modport master (
    output cfg_valid, cfg_freq, cfg_h_active, cfg_h_front, cfg_h_sync, cfg_h_back,
    output cfg_v_active, cfg_v_front, cfg_v_sync, cfg_v_back,
    input  cfg_ready, cfg_err
  );

  modport slave (
    input  cfg_valid, cfg_freq, cfg_h_active, cfg_h_front, cfg_h_sync, cfg_h_back,
    input  cfg_v_active, cfg_v_front, cfg_v_sync, cfg_v_back,
    output cfg_ready, cfg_err
  );
`endif
endinterface

// File: rtl/video_timing_ctrl.sv
// Video timing sequencer for the fractional pixel-clock-enable generator.
// Accepts a mode over the cfg bus into a shadow register, applies it at a frame
// boundary (or immediately from idle), drives the rate word to the enable
// generator and, on every returned pixel enable, emits registered sync / de /
// coordinates for the current counter position.
//
// Ports:
//   clk, rst_ni   clock, asynchronous active-low reset
//   cfg           video_timing_ctrl_if.slave: mode offer, cfg_ready, cfg_err
//   pix_en        pixel enable from the enable generator
//   freq          rate word to the enable generator (0 while idle)
//   hsync, vsync  registered syncs
//   de            registered data enable
//   x, y          position of the current pixel
//   frame_start   one-cycle pulse with pixel (0,0)
//   pix_stb       one-cycle pulse whenever outputs were updated for a pixel
//
// Optional feature macro: VIDEO_TIMING_SYNC_POL_EN (per-mode sync polarity).
module video_timing_ctrl #(
  parameter int unsigned H_WIDTH    = 12,
  parameter int unsigned V_WIDTH    = 11,
  parameter int unsigned FREQ_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_ni,
  video_timing_ctrl_if.slave    cfg,
  input  logic                  pix_en,
  output logic [FREQ_WIDTH-1:0] freq,
  output logic                  hsync,
  output logic                  vsync,
  output logic                  de,
  output logic [H_WIDTH-1:0]    x,
  output logic [V_WIDTH-1:0]    y,
  output logic                  frame_start,
  output logic                  pix_stb
);

  localparam logic [0:0] StIdle = 1'b0;
  localparam logic [0:0] StRun  = 1'b1;

  localparam logic [H_WIDTH-1:0] HOne = H_WIDTH'(1);
  localparam logic [V_WIDTH-1:0] VOne = V_WIDTH'(1);

  // Mode held in decoded form: segment boundaries are precomputed on accept so
  // the pixel path only compares.
  typedef struct packed {
    logic [FREQ_WIDTH-1:0] freq;
    logic [H_WIDTH-1:0]    h_active;
    logic [H_WIDTH-1:0]    h_sync_start;
    logic [H_WIDTH-1:0]    h_sync_end;
    logic [H_WIDTH-1:0]    h_last;
    logic [V_WIDTH-1:0]    v_active;
    logic [V_WIDTH-1:0]    v_sync_start;
    logic [V_WIDTH-1:0]    v_sync_end;
    logic [V_WIDTH-1:0]    v_last;
`ifdef VIDEO_TIMING_SYNC_POL_EN
    logic                  hpol;
    logic                  vpol;
`endif
  } mode_t;

  logic [0:0]         state_q, state_d;
  logic               pending_q, pending_d;
  mode_t              shadow_q, shadow_d;
  mode_t              active_q, active_d;
  mode_t              cfg_mode;
  logic [H_WIDTH-1:0] h_q, h_d;
  logic [V_WIDTH-1:0] v_q, v_d;
  logic               hsync_q, hsync_d;
  logic               vsync_q, vsync_d;
  logic               de_q, de_d;
  logic [H_WIDTH-1:0] x_q, x_d;
  logic [V_WIDTH-1:0] y_q, y_d;
  logic               fs_q, fs_d;
  logic               stb_q, stb_d;
  logic               err_q, err_d;

  // Sums are two bits wider than the fields so an overflowing total is visible.
  logic [H_WIDTH+1:0] h_ss, h_se, h_tot;
  logic [V_WIDTH+1:0] v_ss, v_se, v_tot;
  logic               cfg_ok;
  logic               xfer;
  logic               emit;
  logic               at_h_end, at_v_end;
  logic               apply;
  logic               hs_act, vs_act;

  // Offered mode: decode and validate.
  always_comb begin
    h_ss  = {2'b00, cfg.cfg_h_active} + {2'b00, cfg.cfg_h_front};
    h_se  = h_ss + {2'b00, cfg.cfg_h_sync};
    h_tot = h_se + {2'b00, cfg.cfg_h_back};
    v_ss  = {2'b00, cfg.cfg_v_active} + {2'b00, cfg.cfg_v_front};
    v_se  = v_ss + {2'b00, cfg.cfg_v_sync};
    v_tot = v_se + {2'b00, cfg.cfg_v_back};

    cfg_ok = (|cfg.cfg_h_active) & (|cfg.cfg_h_sync) & (|cfg.cfg_v_active) &
             (|cfg.cfg_v_sync) & (|cfg.cfg_freq) &
             ~(|{h_ss[H_WIDTH+1:H_WIDTH], h_se[H_WIDTH+1:H_WIDTH], h_tot[H_WIDTH+1:H_WIDTH]}) &
             ~(|{v_ss[V_WIDTH+1:V_WIDTH], v_se[V_WIDTH+1:V_WIDTH], v_tot[V_WIDTH+1:V_WIDTH]});

    cfg_mode              = '0;
    cfg_mode.freq         = cfg.cfg_freq;
    cfg_mode.h_active     = cfg.cfg_h_active;
    cfg_mode.h_sync_start = h_ss[H_WIDTH-1:0];
    cfg_mode.h_sync_end   = h_se[H_WIDTH-1:0];
    cfg_mode.h_last       = h_tot[H_WIDTH-1:0] - HOne;
    cfg_mode.v_active     = cfg.cfg_v_active;
    cfg_mode.v_sync_start = v_ss[V_WIDTH-1:0];
    cfg_mode.v_sync_end   = v_se[V_WIDTH-1:0];
    cfg_mode.v_last       = v_tot[V_WIDTH-1:0] - VOne;
`ifdef VIDEO_TIMING_SYNC_POL_EN
    cfg_mode.hpol         = cfg.cfg_hpol;
    cfg_mode.vpol         = cfg.cfg_vpol;
`endif
  end

  assign cfg.cfg_ready = ~pending_q;
  assign cfg.cfg_err   = err_q;

  // Sequencing and pixel emission.
  always_comb begin
    xfer     = cfg.cfg_valid & ~pending_q;
    emit     = (state_q == StRun) & pix_en;
    at_h_end = (h_q == active_q.h_last);
    at_v_end = (v_q == active_q.v_last);
    // pending_q is the pre-handshake value, so a mode accepted on the
    // frame-end cycle waits a full frame.
    apply    = (state_q == StIdle) ? pending_q : (emit & pending_q & at_h_end & at_v_end);

    state_d   = apply ? StRun : state_q;
    pending_d = pending_q;
    shadow_d  = shadow_q;
    // xfer needs pending_q == 0 and apply needs pending_q == 1: never both.
    if (apply) begin
      pending_d = 1'b0;
    end else if (xfer && cfg_ok) begin
      pending_d = 1'b1;
      shadow_d  = cfg_mode;
    end
    active_d = apply ? shadow_q : active_q;
    err_d    = xfer & ~cfg_ok;

    h_d = h_q;
    v_d = v_q;
    if (apply) begin
      h_d = '0;
      v_d = '0;
    end else if (emit) begin
      if (at_h_end) begin
        h_d = '0;
        v_d = at_v_end ? '0 : v_q + VOne;
      end else begin
        h_d = h_q + HOne;
      end
    end

    hs_act = (h_q >= active_q.h_sync_start) && (h_q < active_q.h_sync_end);
    vs_act = (v_q >= active_q.v_sync_start) && (v_q < active_q.v_sync_end);

    hsync_d = hsync_q;
    vsync_d = vsync_q;
    de_d    = de_q;
    x_d     = x_q;
    y_d     = y_q;
    fs_d    = 1'b0;
    stb_d   = emit;
    if (emit) begin
`ifdef VIDEO_TIMING_SYNC_POL_EN
      hsync_d = hs_act ~^ active_q.hpol;
      vsync_d = vs_act ~^ active_q.vpol;
`else
      hsync_d = hs_act;
      vsync_d = vs_act;
`endif
      de_d    = (h_q < active_q.h_active) && (v_q < active_q.v_active);
      x_d     = h_q;
      y_d     = v_q;
      fs_d    = (h_q == '0) && (v_q == '0);
    end
  end

  always_ff @(posedge clk or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= StIdle;
      pending_q <= 1'b0;
      shadow_q  <= '0;
      active_q  <= '0;
      h_q       <= '0;
      v_q       <= '0;
      hsync_q   <= 1'b0;
      vsync_q   <= 1'b0;
      de_q      <= 1'b0;
      x_q       <= '0;
      y_q       <= '0;
      fs_q      <= 1'b0;
      stb_q     <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      shadow_q  <= shadow_d;
      active_q  <= active_d;
      h_q       <= h_d;
      v_q       <= v_d;
      hsync_q   <= hsync_d;
      vsync_q   <= vsync_d;
      de_q      <= de_d;
      x_q       <= x_d;
      y_q       <= y_d;
      fs_q      <= fs_d;
      stb_q     <= stb_d;
      err_q     <= err_d;
    end
  end

  // active_q resets to zero, so freq is 0 until the first mode applies.
  assign freq        = active_q.freq;
  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign de          = de_q;
  assign x           = x_q;
  assign y           = y_q;
  assign frame_start = fs_q;
  assign pix_stb     = stb_q;

endmodule
